// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset defaults, NOP encoding,
// FSM state encoding and the buffered entry layout.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response path and decode.
// Registered output (no bypass), synchronous clear, occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [63:0]              i_data,
    input  logic                     i_pop,
    output logic [63:0]              o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A pop frees the head slot in the same edge, so a full buffer can still accept.
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests, tracks in-flight reads, buffers
// responses with their PCs and discards stale responses after a redirect.
//
// state    | meaning
// ST_RUN   | normal fetch, every accepted response is buffered
// ST_DRAIN | responses issued before the last redirect are still returning and get dropped
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_discard_nxt;

    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_in_flight;
    logic          w_fifo_empty;
    logic [63:0]   w_fifo_rdata;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head_entry;

    logic w_xfer;
    logic w_rsp;
    logic w_drop;
    logic w_push;
    logic w_pop;

    // Occupancy counts both buffered words and words still in flight so a burst of
    // responses can never overrun the buffer.
    assign w_in_flight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_o  = ~reset & ~redirect_i & (w_in_flight < (CW+1)'(FIFO_DEPTH));
    assign imem_addr_o = r_fetch_pc;

    assign w_xfer = imem_req_o & imem_gnt_i;
    // A response with nothing outstanding belongs to a request lost to reset.
    assign w_rsp  = imem_rvalid_i & (r_outstanding != '0);
    assign w_drop = w_rsp & (r_discard != '0);
    assign w_push = w_rsp & ~w_drop & ~redirect_i;
    assign w_pop  = instr_valid_o & instr_ready_i & ~redirect_i;

    assign w_push_entry.pc    = r_resp_pc;
    assign w_push_entry.instr = imem_rdata_i;
    assign w_head_entry       = fetch_entry_t'(w_fifo_rdata);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign instr_valid_o = ~w_fifo_empty;
    assign instr_o       = w_fifo_empty ? NOP_INSTR : w_head_entry.instr;
    assign instr_pc_o    = w_fifo_empty ? r_resp_pc : w_head_entry.pc;

    always_comb begin
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        case (r_state)
            ST_RUN: begin
                if (redirect_i) begin
                    w_discard_nxt = r_outstanding - CW'(w_rsp);
                end
            end
            ST_DRAIN: begin
                if (redirect_i) begin
                    w_discard_nxt = r_outstanding - CW'(w_rsp);
                end else if (w_drop) begin
                    w_discard_nxt = r_discard - CW'(1);
                end
            end
            default: w_discard_nxt = '0;
        endcase
        w_state_nxt = (w_discard_nxt != '0) ? ST_DRAIN : ST_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_discard <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_xfer, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else if (redirect_i) begin
            r_fetch_pc <= word_align(redirect_pc_i);
            r_resp_pc  <= word_align(redirect_pc_i);
        end else begin
            if (w_xfer) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-cycle-latency instruction memory model
// answers granted requests in order with a PC-derived word.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    int          total = 0;
    int          bad   = 0;
    bit          rsp_en;
    logic [31:0] pend[$];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        xfer;
        logic [31:0] a;
        @(negedge clk);
        xfer = imem_req_o & imem_gnt_i;
        a    = imem_addr_o;
        @(posedge clk);
        #1;
        if (imem_rvalid_i && pend.size() > 0) pend.delete(0);
        if (xfer) pend.push_back(a);
        if (rsp_en && pend.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
        rsp_en        = 1'b1;
        #2;
        chk("rst_req",   {31'h0, imem_req_o},    32'h0);
        chk("rst_addr",  imem_addr_o,            32'h0);
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_instr", instr_o,                32'h0000_0013);
        chk("rst_pc",    instr_pc_o,             32'h0);

        // Streaming fetch with no stalls
        imem_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b1;
        do_reset();
        chk("a_req_c0", {31'h0, imem_req_o}, 32'h1);
        tick();
        chk("a_valid_c1", {31'h0, instr_valid_o}, 32'h0);
        chk("a_addr_c1",  imem_addr_o,            32'h4);
        tick();
        chk("a_pc_c2",    instr_pc_o, 32'h0);
        chk("a_instr_c2", instr_o,    mem_word(32'h0));
        tick();
        chk("a_pc_c3",    instr_pc_o, 32'h4);
        tick();
        chk("a_pc_c4",    instr_pc_o, 32'h8);

        // Decode stall fills the buffer, then drains in order
        instr_ready_i = 1'b0;
        repeat (10) tick();
        chk("b_req_full", {31'h0, imem_req_o},    32'h0);
        chk("b_valid",    {31'h0, instr_valid_o}, 32'h1);
        chk("b_head_pc",  instr_pc_o,             32'h8);
        chk("b_addr",     imem_addr_o,            32'd24);
        instr_ready_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("b_resume_pc",    instr_pc_o, 32'h8 + 32'(4 * k));
            chk("b_resume_instr", instr_o,    mem_word(32'h8 + 32'(4 * k)));
        end

        // Grant withheld for five cycles
        imem_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b1;
        do_reset();
        tick();
        tick();
        imem_gnt_i = 1'b0;
        chk("c_addr_c2", imem_addr_o, 32'h8);
        chk("c_pc_c2",   instr_pc_o,  32'h0);
        tick();
        chk("c_addr_c3", imem_addr_o, 32'h8);
        chk("c_pc_c3",   instr_pc_o,  32'h4);
        tick();
        chk("c_addr_c4",  imem_addr_o,            32'h8);
        chk("c_valid_c4", {31'h0, instr_valid_o}, 32'h0);
        tick();
        tick();
        chk("c_addr_c6", imem_addr_o,         32'h8);
        chk("c_req_c6",  {31'h0, imem_req_o}, 32'h1);

        // Redirect with two responses outstanding; misaligned target
        imem_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b0;
        do_reset();
        tick();
        tick();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102; rsp_en = 1'b1;
        #1;
        chk("d_req_redirect", {31'h0, imem_req_o}, 32'h0);
        tick();
        redirect_i = 1'b0; imem_gnt_i = 1'b1;
        #1;
        chk("d_addr_c3",  imem_addr_o,            32'h100);
        chk("d_valid_c3", {31'h0, instr_valid_o}, 32'h0);
        tick();
        chk("d_valid_c4", {31'h0, instr_valid_o}, 32'h0);
        tick();
        chk("d_valid_c5", {31'h0, instr_valid_o}, 32'h0);
        tick();
        chk("d_pc_c6",    instr_pc_o, 32'h100);
        chk("d_instr_c6", instr_o,    mem_word(32'h100));
        tick();
        chk("d_pc_c7",    instr_pc_o, 32'h104);

        // Redirect coinciding with a response and a pop
        imem_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b0;
        do_reset();
        tick();
        rsp_en = 1'b1;
        tick();
        tick();
        chk("e_pc_c3", instr_pc_o, 32'h0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        #1;
        chk("e_valid_c4", {31'h0, instr_valid_o}, 32'h0);
        chk("e_addr_c4",  imem_addr_o,            32'h200);
        tick();
        chk("e_valid_c5", {31'h0, instr_valid_o}, 32'h0);
        tick();
        chk("e_pc_c6",    instr_pc_o, 32'h200);
        chk("e_instr_c6", instr_o,    mem_word(32'h200));
        tick();
        chk("e_pc_c7",    instr_pc_o, 32'h204);

        // Reset asserted with three requests in flight
        imem_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("f_req",   {31'h0, imem_req_o},    32'h0);
        chk("f_addr",  imem_addr_o,            32'h0);
        chk("f_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("f_instr", instr_o,                32'h0000_0013);
        chk("f_pc",    instr_pc_o,             32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; pend.delete(); imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        #1;
        tick();
        chk("f_late_valid1", {31'h0, instr_valid_o}, 32'h0);
        tick();
        chk("f_late_valid2", {31'h0, instr_valid_o}, 32'h0);
        chk("f_addr_hold",   imem_addr_o,            32'h0);
        imem_gnt_i = 1'b1; rsp_en = 1'b1;
        tick();
        chk("f_valid_c3", {31'h0, instr_valid_o}, 32'h0);
        tick();
        chk("f_pc_c4",    instr_pc_o, 32'h0);
        chk("f_instr_c4", instr_o,    mem_word(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of 2, 2..16).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 redirect_i  input  1  branch/JAL/JALR taken from MEM stage; flush and restart.
REQ-006 redirect_pc_i  input  32  restart address, sampled when redirect_i=1.
REQ-007 imem_req_o  output  1  fetch request valid.
REQ-008 imem_addr_o  output  32  fetch word address (byte address, [1:0]=0).
REQ-009 imem_gnt_i  input  1  request accepted this cycle.
REQ-010 imem_rvalid_i  input  1  in-order read response valid.
REQ-011 imem_rdata_i  input  32  instruction word of response.
REQ-012 instr_valid_o  output  1  IF/ID entry valid.
REQ-013 instr_ready_i  input  1  decode accepts entry (deasserted = stall).
REQ-014 instr_o  output  32  instruction to IF/ID register.
REQ-015 instr_pc_o  output  32  PC of instr_o.

Function
REQ-016 Request handshake: transfer when imem_req_o & imem_gnt_i; fetch_pc += 4 on transfer; imem_addr_o = fetch_pc.
REQ-017 imem_req_o SHALL assert only when outstanding + fifo_count < FIFO_DEPTH and redirect_i=0; never overflow buffer.
REQ-018 Outstanding counter: +1 on transfer, -1 on imem_rvalid_i, both same cycle = unchanged; range 0..FIFO_DEPTH.
REQ-019 Accepted response (not discarded) SHALL push {resp_pc, imem_rdata_i} into FIFO; resp_pc += 4 per push.
REQ-020 Output: instr_valid_o = FIFO not empty; instr_o/instr_pc_o = FIFO head; pop on instr_valid_o & instr_ready_i.
REQ-021 Latency: response in cycle N visible on instr_valid_o in cycle N+1 (registered FIFO, no bypass).
REQ-022 Simultaneous push and pop on full FIFO SHALL be allowed; on empty FIFO push only (no bypass).
REQ-023 Redirect cycle: FIFO cleared, fetch_pc and resp_pc <= redirect_pc_i, discard_cnt <= outstanding - (imem_rvalid_i ? 1 : 0), outstanding tracking preserved; instr_valid_o=0 next cycle.
REQ-024 While discard_cnt > 0 each imem_rvalid_i SHALL decrement discard_cnt and not push.
REQ-025 States: RUN (normal), DRAIN (discard_cnt>0; requests to new PC permitted, responses dropped); DRAIN->RUN when discard_cnt reaches 0.
REQ-026 Redirect during DRAIN SHALL recompute discard_cnt from current outstanding per REQ-023.
REQ-027 redirect_i has priority over pop, push and request in the same cycle.
REQ-028 Counters/pointers wrap modulo FIFO_DEPTH; fetch_pc wraps modulo 2^32.
REQ-029 redirect_pc_i[1:0] SHALL be forced to 0 internally.

Reset
REQ-030 On reset: fetch_pc=resp_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state RUN.
REQ-031 Reset outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), instr_pc_o=RESET_PC.
REQ-032 imem_req_o SHALL first assert in the first cycle after reset deasserts.
REQ-033 Reset mid-operation SHALL drop all in-flight responses' effect (outstanding cleared; late rvalid after reset ignored while outstanding=0).

Structure
REQ-034 Shared package SHALL hold RESET_PC default, NOP_INSTR (32'h0000_0013), state encoding (RUN, DRAIN).
REQ-035 Buffer SHALL be sub-module fetch_fifo (64-bit entries, sync clear, count output).

Verification
REQ-036 Reset release, gnt=1, rvalid one cycle after gnt, ready=1 -> instr_pc_o 0x0,0x4,0x8 consecutive cycles, first valid 2 cycles after first request.
REQ-037 ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered, imem_req_o low, no word lost; ready=1 -> PCs resume in order.
REQ-038 Redirect to 0x100 with 2 outstanding -> next 2 responses dropped, first valid output instr_pc_o=0x100.
REQ-039 Redirect coincident with rvalid and pop -> discard_cnt=outstanding-1, FIFO empty next cycle, no stale PC emitted.
REQ-040 gnt held low 5 cycles -> imem_addr_o stable, fetch_pc unchanged, instr_valid_o drops after FIFO drains.
REQ-041 Assert reset with 3 outstanding -> all outputs at reset values immediately; late rvalid ignored; fetch restarts at RESET_PC.
